param_fetch_arbiter: RTL and testbench

- Shares the single-port layer-parameter BRAM between NUM_REQ parameter consumers: the input write controllers and the weight write controller.
- Each consumer has an address channel (valid/ready) and a data channel (valid/ready), the same split used between the input write controllers.
- Arbitration is round-robin, with one outstanding read at a time.
- Read data returns only to the requester that issued the address.

---
 rtl/param_fetch_arbiter.sv | 153 +++++++++++++++
 tb/tb_param_fetch_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : param_fetch_arbiter
// Description : Round-robin arbiter sharing the single-port layer-parameter
//               BRAM between NUM_REQ consumers, one outstanding read at a time.
//               Define PARAM_FETCH_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module param_fetch_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int PARAM_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RD_LATENCY  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                   req_addr_valid,
  output logic [NUM_REQ-1:0]                   req_addr_ready,
  output logic [PARAM_WIDTH-1:0]               req_data,
  output logic [NUM_REQ-1:0]                   req_data_valid,
  input  logic [NUM_REQ-1:0]                   req_data_ready,
  output logic                                 mem_en,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic [PARAM_WIDTH-1:0]               mem_rdata,
  output logic                                 busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [LAT_W-1:0] c_lat_last = LAT_W'(RD_LATENCY - 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  logic [1:0]             r_state;
  logic [PTR_W-1:0]       r_owner;
  logic [LAT_W-1:0]       r_lat_cnt;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [PARAM_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]     r_data_valid;

  logic [PTR_W-1:0]       w_grant;
  logic                   w_any_valid;
  logic [ADDR_WIDTH-1:0]  w_gnt_addr;
  logic [NUM_REQ-1:0]     w_owner_oh;
  logic                   w_data_hs;

`ifdef PARAM_FETCH_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    w_grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_addr_valid[i]) w_grant = i[PTR_W-1:0];
    end
  end
`else
  localparam logic [PTR_W-1:0] c_last_req = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   c_num_ext  = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W:0]   w_scan;

  // Circular scan from r_rr_ptr; descending offsets so the nearest valid wins.
  always_comb begin
    w_grant = '0;
    w_scan  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + k[PTR_W:0];
      if (w_scan >= c_num_ext) w_scan = w_scan - c_num_ext;
      if (req_addr_valid[w_scan[PTR_W-1:0]]) w_grant = w_scan[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (r_state == c_resp && w_data_hs) begin
      r_rr_ptr <= (r_owner == c_last_req) ? '0 : r_owner + 1'b1;
    end
  end
`endif

  assign w_any_valid = |req_addr_valid;

  always_comb begin
    w_gnt_addr     = '0;
    req_addr_ready = '0;
    w_owner_oh     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == i[PTR_W-1:0]) begin
        w_gnt_addr        = req_addr[i];
        req_addr_ready[i] = (r_state == c_idle) && w_any_valid;
      end
      w_owner_oh[i] = (r_owner == i[PTR_W-1:0]);
    end
  end

  // r_data_valid is already one-hot on the owner, so non-owner readies drop out.
  assign w_data_hs = |(r_data_valid & req_data_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_idle;
      r_owner      <= '0;
      r_lat_cnt    <= '0;
      r_mem_addr   <= '0;
      r_data       <= '0;
      r_data_valid <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any_valid) begin
            r_owner    <= w_grant;
            r_mem_addr <= w_gnt_addr;
            r_state    <= c_issue;
          end
        end
        c_issue: begin
          r_lat_cnt <= '0;
          r_state   <= c_wait;
        end
        c_wait: begin
          if (r_lat_cnt == c_lat_last) begin
            r_data       <= mem_rdata;
            r_data_valid <= w_owner_oh;
            r_state      <= c_resp;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        c_resp: begin
          if (w_data_hs) begin
            r_data_valid <= '0;
            r_state      <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign mem_en         = (r_state == c_issue);
  assign mem_addr       = r_mem_addr;
  assign req_data       = r_data;
  assign req_data_valid = r_data_valid;
  assign busy           = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_param_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_fetch_arbiter
// Description : Directed self-checking bench for param_fetch_arbiter with a
//               two-cycle BRAM model. Honours PARAM_FETCH_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fetch_arbiter;

  localparam int NR = 3;
  localparam int PW = 32;
  localparam int AW = 8;
  localparam int RL = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NR-1:0][AW-1:0]   req_addr;
  logic [NR-1:0]           req_addr_valid;
  logic [NR-1:0]           req_addr_ready;
  logic [PW-1:0]           req_data;
  logic [NR-1:0]           req_data_valid;
  logic [NR-1:0]           req_data_ready;
  logic                    mem_en;
  logic [AW-1:0]           mem_addr;
  logic [PW-1:0]           mem_rdata;
  logic                    busy;
  logic [PW-1:0]           mem_p1;

  int n_tests = 0;
  int n_fail  = 0;
  int grants[6];
  int hs_cyc[6];
  int ng;
  int last_g;

  always #5 clk = ~clk;

  param_fetch_arbiter #(
    .NUM_REQ(NR), .PARAM_WIDTH(PW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_addr_valid(req_addr_valid), .req_addr_ready(req_addr_ready),
    .req_data(req_data), .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [PW-1:0] mem_f(input logic [AW-1:0] a);
    return (a == 8'h05) ? 32'hDEADBEEF : (32'hC0FFEE00 | {24'h0, a});
  endfunction

  // BRAM model: data appears two cycles after the mem_en cycle.
  always @(posedge clk) begin
    mem_p1    <= mem_en ? mem_f(mem_addr) : 32'h0BAD0BAD;
    mem_rdata <= mem_p1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    req_addr_valid = '0;
    req_data_ready = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic run_txn(input logic [NR-1:0] vmask, input int exp_g, input string tag);
    int n;
    req_data_ready = '1;
    req_addr_valid = vmask;
    #1;
    n = 0;
    while (n < 20 && !(|(req_addr_ready & req_addr_valid))) begin
      step(); #1; n++;
    end
    check({tag, "_grant"}, req_addr_ready, 3'b001 << exp_g);
    step();
    req_addr_valid = '0;
    #1;
    n = 0;
    while (n < 20 && req_data_valid == '0) begin
      step(); #1; n++;
    end
    check({tag, "_dv"}, req_data_valid, 3'b001 << exp_g);
    check({tag, "_data"}, req_data, mem_f(req_addr[exp_g]));
    step(); #1;
    check({tag, "_idle"}, {busy, req_data_valid}, 4'b0);
  endtask

  initial begin
    rst_n          = 1'b1;
    req_addr       = '0;
    req_addr_valid = '0;
    req_data_ready = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_addr_ready", req_addr_ready, 0);
    check("rst_dv", req_data_valid, 0);
    check("rst_data", req_data, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    step();
    rst_n = 1'b1;

    // Single read from requester 1
    do_reset();
    req_addr[1]    = 8'h05;
    req_addr_valid = 3'b010;
    #1;
    check("sr_addr_ready", req_addr_ready, 3'b010);
    step(); req_addr_valid = '0; #1;
    check("sr_mem_en", mem_en, 1);
    check("sr_mem_addr", mem_addr, 8'h05);
    check("sr_busy", busy, 1);
    step(); #1;
    check("sr_dv_t2", {mem_en, req_data_valid}, 0);
    step(); #1;
    check("sr_dv_t3", req_data_valid, 0);
    step(); #1;
    check("sr_dv_t4", req_data_valid, 3'b010);
    check("sr_data_t4", req_data, 32'hDEADBEEF);
    req_data_ready = 3'b101;
    step(); #1;
    check("sr_nonowner_ready", req_data_valid, 3'b010);
    req_data_ready = 3'b010;
    step(); #1;
    check("sr_dv_cleared", {busy, req_data_valid}, 0);

    // Backpressure from owner 2 while requester 0 waits
    do_reset();
    req_addr[2]    = 8'h22;
    req_addr[0]    = 8'h30;
    req_addr_valid = 3'b100;
    #1;
    check("bp_grant2", req_addr_ready, 3'b100);
    step(); req_addr_valid = 3'b001; #1;
    check("bp_hold_t1", req_addr_ready, 0);
    step(); #1;
    check("bp_hold_t2", req_addr_ready, 0);
    step(); #1;
    check("bp_hold_t3", req_addr_ready, 0);
    step(); #1;
    for (int i = 0; i < 6; i++) begin
      check("bp_dv", req_data_valid, 3'b100);
      check("bp_data", req_data, mem_f(8'h22));
      check("bp_ready0", req_addr_ready, 0);
      step(); #1;
    end
    req_data_ready = 3'b100;
    #1;
    check("bp_hs_dv", {req_addr_ready, req_data_valid}, {3'b000, 3'b100});
    step(); #1;
    check("bp_grant0", req_addr_ready, 3'b001);
    check("bp_after_hs", {busy, req_data_valid}, 0);
    step(); req_addr_valid = '0; req_data_ready = '1; #1;
    check("bp_mem_en0", {mem_en, mem_addr}, {1'b1, 8'h30});
    for (int i = 0; i < 6; i++) step();

    req_addr[0] = 8'h40;
    req_addr[1] = 8'h41;
    req_addr[2] = 8'h42;
`ifdef PARAM_FETCH_FIXED_PRIO_EN
    run_txn(3'b101, 0, "fp_a");
    run_txn(3'b101, 0, "fp_b");
    run_txn(3'b111, 0, "fp_c");
    run_txn(3'b100, 2, "fp_d");
    run_txn(3'b101, 0, "fp_e");
`else
    // Pointer sits at 1 here: serve 2 (wrap to 0), then 0 beats 1, then 1.
    run_txn(3'b100, 2, "wrap_a");
    run_txn(3'b011, 0, "wrap_b");
    run_txn(3'b011, 1, "wrap_c");
    run_txn(3'b101, 2, "alt_a");
    run_txn(3'b101, 0, "alt_b");

    // Continuous round robin with all requesters valid
    do_reset();
    req_addr[0]    = 8'h10;
    req_addr[1]    = 8'h11;
    req_addr[2]    = 8'h12;
    req_data_ready = '1;
    req_addr_valid = '1;
    ng     = 0;
    last_g = 0;
    for (int k = 0; k < 6; k++) begin grants[k] = -1; hs_cyc[k] = -1; end
    #1;
    for (int n = 0; n < 80 && ng < 6; n++) begin
      if (|(req_addr_ready & req_addr_valid)) begin
        last_g     = oh_idx(req_addr_ready);
        grants[ng] = last_g;
        hs_cyc[ng] = n;
        ng++;
      end else if (req_data_valid != '0) begin
        check("rr_dv", req_data_valid, 3'b001 << last_g);
        check("rr_data", req_data, mem_f(8'h10 + 8'(last_g)));
      end
      step(); #1;
    end
    req_addr_valid = '0;
    check("rr_count", ng, 6);
    for (int k = 0; k < 6; k++) check("rr_order", grants[k], k % 3);
    for (int k = 1; k < 6; k++) check("rr_spacing", hs_cyc[k] - hs_cyc[k-1], 5);
    for (int i = 0; i < 6; i++) step();
`endif

    // Reset asserted during WAIT
    req_addr[1]    = 8'h07;
    req_data_ready = '1;
    req_addr_valid = 3'b010;
    #1;
    check("rw_grant", req_addr_ready, 3'b010);
    step(); req_addr_valid = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("rw_outs", {req_addr_ready, req_data_valid, mem_en, busy}, 0);
    check("rw_data", req_data, 0);
    check("rw_mem_addr", mem_addr, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rw_no_dv", {busy, req_data_valid}, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
